// File: rtl/evm_multi_party.sv
// ---------------------------------------------------------------------------
// evm_multi_party
//
// Purpose:
//    N-party electronic voting machine core. It sits between the ballot panel
//    (one-hot party switches and a cast button) and the result displays.
//    A presiding-officer arm/lockout FSM lets exactly one vote through per
//    arm. The push button is edge-detected. Per-party counters saturate and
//    set a sticky overflow flag. A registered total and two 7-segment decodes
//    drive the result displays.
//
// Configuration macro:
//    EVM_WINNER_EN - when defined, adds a sequential winner scan and the
//                    o_winner / o_winner_valid / o_tie outputs.
//
// Parameters:
//    N_PARTY  number of parties, which is also the one-hot switch width (2..16)
//    CNT_W    per-party counter width
//    SEL_W    (derived) party-select width, $clog2(N_PARTY)
//    TOT_W    (derived) total width, CNT_W + SEL_W, so the total never wraps
//
// Ports:
//    i_clk            system clock, all logic on the rising edge
//    i_reset_n        synchronous active-low reset
//    i_voting_en      session enable
//    i_officer_arm    officer arm level, sampled in READY
//    i_voter_switch   one-hot party choice [N_PARTY]
//    i_push_button    cast button, already synchronised
//    i_sel_party      party shown on the displays / o_party_count [SEL_W]
//    i_show_count     1 = drive o_seg_count, 0 = blank it
//    o_party_count    count of the selected party, 0 when out of range [CNT_W]
//    o_total_count    registered sum of all counters [TOT_W]
//    o_vote_ack       1-cycle pulse, vote committed
//    o_invalid_vote   1-cycle pulse, button edge with a non-one-hot switch
//    o_overflow       sticky, a vote hit a saturated counter
//    o_busy           1 in ARMED / COMMIT / LOCKOUT
//    o_seg_party      active-low abcdefg, digit i_sel_party+1
//    o_seg_count      active-low abcdefg, hex of o_party_count[3:0]
//    o_winner         (EVM_WINNER_EN) index of the highest count [SEL_W]
//    o_winner_valid   (EVM_WINNER_EN) scan finished, o_winner is stable
//    o_tie            (EVM_WINNER_EN) the maximum is shared
// ---------------------------------------------------------------------------
module evm_multi_party #(
    parameter int N_PARTY = 4,
    parameter int CNT_W   = 8,
    localparam int SEL_W  = (N_PARTY > 1) ? $clog2(N_PARTY) : 1,
    localparam int TOT_W  = CNT_W + SEL_W
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_voting_en,
    input  logic               i_officer_arm,
    input  logic [N_PARTY-1:0] i_voter_switch,
    input  logic               i_push_button,
    input  logic [SEL_W-1:0]   i_sel_party,
    input  logic               i_show_count,
    output logic [CNT_W-1:0]   o_party_count,
    output logic [TOT_W-1:0]   o_total_count,
    output logic               o_vote_ack,
    output logic               o_invalid_vote,
    output logic               o_overflow,
    output logic               o_busy,
    output logic [6:0]         o_seg_party,
    output logic [6:0]         o_seg_count
`ifdef EVM_WINNER_EN
    ,
    output logic [SEL_W-1:0]   o_winner,
    output logic               o_winner_valid,
    output logic               o_tie
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_ARMED,
        ST_COMMIT,
        ST_LOCKOUT
    } evmState_t;

    evmState_t          r_state;
    evmState_t          w_nextState;

    logic               r_btnQ;
    logic               w_btnRise;
    logic               w_switchOneHot;
    logic [SEL_W-1:0]   w_switchIdx;
    logic               w_acceptVote;
    logic               w_rejectVote;

    logic [SEL_W-1:0]   r_voteIdx;
    logic [CNT_W-1:0]   r_count [N_PARTY];
    logic [CNT_W-1:0]   w_voteCount;
    logic               w_saturated;

    logic [TOT_W-1:0]   r_total;
    logic [TOT_W-1:0]   w_sum;
    logic               r_overflow;
    logic               r_invalid;

    int                 w_partyDigit;
    logic [3:0]         w_countNibble;

    // Active-low abcdefg patterns for one hex digit.
    function automatic logic [6:0] hexToSeg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Only a rising edge of the button can cast, so a held button never
    // produces a second vote.
    assign w_btnRise = i_push_button & ~r_btnQ;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves
    // nothing.
    assign w_switchOneHot = (i_voter_switch != '0) &&
                            ((i_voter_switch & (i_voter_switch - 1'b1)) == '0);

    // Binary index of the switch. The value only matters when the switch is
    // one-hot.
    always_comb begin
        w_switchIdx = '0;
        for (int p = 0; p < N_PARTY; p++) begin
            if (i_voter_switch[p]) begin
                w_switchIdx = SEL_W'(p);
            end
        end
    end

    // Counter value of the party latched for the pending commit.
    always_comb begin
        w_voteCount = '0;
        for (int p = 0; p < N_PARTY; p++) begin
            if (r_voteIdx == SEL_W'(p)) begin
                w_voteCount = r_count[p];
            end
        end
    end

    assign w_saturated = (w_voteCount == {CNT_W{1'b1}});

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state. A COMMIT already in flight always completes. Dropping
    // the session enable from ARMED discards the uncast vote silently.
    always_comb begin
        w_nextState  = r_state;
        w_acceptVote = 1'b0;
        w_rejectVote = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_voting_en) begin
                    w_nextState = ST_READY;
                end
            end
            ST_READY: begin
                if (i_officer_arm) begin
                    w_nextState = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_btnRise) begin
                    if (w_switchOneHot) begin
                        w_acceptVote = 1'b1;
                        w_nextState  = ST_COMMIT;
                    end else begin
                        w_rejectVote = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                w_nextState = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (!i_push_button && !i_officer_arm) begin
                    w_nextState = ST_READY;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (!i_voting_en) begin
            w_nextState  = ST_IDLE;
            w_acceptVote = 1'b0;
            w_rejectVote = 1'b0;
        end
    end

    // Datapath: button history, the latched vote index, the counters, the
    // sticky overflow flag, the invalid pulse and the registered total. A
    // saturated counter holds its value and only raises the overflow flag.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_btnQ     <= 1'b0;
            r_voteIdx  <= '0;
            r_total    <= '0;
            r_overflow <= 1'b0;
            r_invalid  <= 1'b0;
            for (int p = 0; p < N_PARTY; p++) begin
                r_count[p] <= '0;
            end
        end else begin
            r_btnQ    <= i_push_button;
            r_invalid <= w_rejectVote;
            r_total   <= w_sum;
            if (w_acceptVote) begin
                r_voteIdx <= w_switchIdx;
            end
            if (r_state == ST_COMMIT) begin
                if (w_saturated) begin
                    r_overflow <= 1'b1;
                end else begin
                    for (int p = 0; p < N_PARTY; p++) begin
                        if (r_voteIdx == SEL_W'(p)) begin
                            r_count[p] <= r_count[p] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Sum of all counters. It lands in r_total one cycle after a count changes.
    always_comb begin
        w_sum = '0;
        for (int p = 0; p < N_PARTY; p++) begin
            w_sum = w_sum + TOT_W'(r_count[p]);
        end
    end

    assign o_total_count  = r_total;
    assign o_overflow     = r_overflow;
    assign o_invalid_vote = r_invalid;
    assign o_vote_ack     = (r_state == ST_COMMIT) && !w_saturated;
    assign o_busy         = (r_state == ST_ARMED) || (r_state == ST_COMMIT) ||
                            (r_state == ST_LOCKOUT);

    // Counter of the displayed party. An out-of-range select reads as 0.
    always_comb begin
        o_party_count = '0;
        for (int p = 0; p < N_PARTY; p++) begin
            if (i_sel_party == SEL_W'(p)) begin
                o_party_count = r_count[p];
            end
        end
    end

    // Low hex nibble of the displayed count. Narrow counters are zero-padded.
    generate
        if (CNT_W >= 4) begin : g_countNibble
            assign w_countNibble = o_party_count[3:0];
        end else begin : g_countNibblePad
            assign w_countNibble = {{(4 - CNT_W){1'b0}}, o_party_count};
        end
    endgenerate

    // The party display shows a 1-based party number. A number that does not
    // fit in one hex digit, or a select past the last party, shows a dash.
    always_comb begin
        w_partyDigit = int'(i_sel_party) + 1;
        o_seg_party  = 7'b1111110;
        if ((int'(i_sel_party) < N_PARTY) && (w_partyDigit <= 15)) begin
            o_seg_party = hexToSeg(4'(w_partyDigit));
        end
    end

    // The count display is blank while reset is held or the display is off.
    always_comb begin
        o_seg_count = 7'b1111111;
        if (i_reset_n && i_show_count) begin
            o_seg_count = hexToSeg(w_countNibble);
        end
    end

`ifdef EVM_WINNER_EN
    logic [SEL_W-1:0] r_scanIdx;
    logic             r_scanning;
    logic [SEL_W-1:0] r_bestIdx;
    logic [CNT_W-1:0] r_bestVal;
    logic             r_tie;
    logic             r_winnerValid;
    logic [CNT_W-1:0] w_scanCount;

    always_comb begin
        w_scanCount = '0;
        for (int p = 0; p < N_PARTY; p++) begin
            if (r_scanIdx == SEL_W'(p)) begin
                w_scanCount = r_count[p];
            end
        end
    end

    // Winner scan: one party per cycle. A commit restarts it so that it reads
    // the updated counts. A strictly larger count takes the lead, so on equal
    // maxima the lowest index stays the winner and the tie flag is set.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_scanIdx     <= '0;
            r_scanning    <= 1'b1;
            r_bestIdx     <= '0;
            r_bestVal     <= '0;
            r_tie         <= 1'b0;
            r_winnerValid <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            r_scanIdx     <= '0;
            r_scanning    <= 1'b1;
            r_winnerValid <= 1'b0;
        end else if (r_scanning) begin
            if (r_scanIdx == '0) begin
                r_bestIdx <= '0;
                r_bestVal <= w_scanCount;
                r_tie     <= 1'b0;
            end else if (w_scanCount > r_bestVal) begin
                r_bestIdx <= r_scanIdx;
                r_bestVal <= w_scanCount;
                r_tie     <= 1'b0;
            end else if (w_scanCount == r_bestVal) begin
                r_tie <= 1'b1;
            end
            if (r_scanIdx == SEL_W'(N_PARTY - 1)) begin
                r_scanning    <= 1'b0;
                r_winnerValid <= 1'b1;
            end else begin
                r_scanIdx <= r_scanIdx + 1'b1;
            end
        end
    end

    assign o_winner       = r_bestIdx;
    assign o_winner_valid = r_winnerValid;
    assign o_tie          = r_tie;
`endif

endmodule

// File: tb/tb_evm_multi_party.sv
// ---------------------------------------------------------------------------
// tb_evm_multi_party
//
// Directed bench for evm_multi_party. The main instance uses 4 parties with
// 2-bit counters, so saturation is reachable in a few votes. A second
// instance with 16 parties and 8-bit counters shares the panel inputs. It is
// used for the full party-digit decode and for the winner scan.
// ---------------------------------------------------------------------------
module tb_evm_multi_party;

    logic        clk = 1'b0;
    logic        resetN;
    logic        votingEn;
    logic        officerArm;
    logic [3:0]  voterSwitch;
    logic        pushButton;
    logic [1:0]  selParty;
    logic [3:0]  selWide;
    logic        showCount;

    logic [1:0]  partyCount;
    logic [3:0]  totalCount;
    logic        voteAck, invalidVote, overflow, busy;
    logic [6:0]  segParty, segCount;

    logic [7:0]  wPartyCount;
    logic [11:0] wTotalCount;
    logic        wVoteAck, wInvalidVote, wOverflow, wBusy;
    logic [6:0]  wSegParty, wSegCount;

`ifdef EVM_WINNER_EN
    logic [1:0]  winner;
    logic        winnerValid, tie;
    logic [3:0]  wWinner;
    logic        wWinnerValid, wTie;
`endif

    typedef struct {
        string tag;
        logic  ack;
    } voteExpect_t;

    voteExpect_t sbQ[$];
    int          modelCnt [4];
    logic        modelOvf;
    int          checks = 0;
    int          errors = 0;
    int          ackCount;

    logic [6:0]  segRef [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    always #5 clk = ~clk;

    evm_multi_party #(.N_PARTY(4), .CNT_W(2)) dut (
        .i_clk          (clk),
        .i_reset_n      (resetN),
        .i_voting_en    (votingEn),
        .i_officer_arm  (officerArm),
        .i_voter_switch (voterSwitch),
        .i_push_button  (pushButton),
        .i_sel_party    (selParty),
        .i_show_count   (showCount),
        .o_party_count  (partyCount),
        .o_total_count  (totalCount),
        .o_vote_ack     (voteAck),
        .o_invalid_vote (invalidVote),
        .o_overflow     (overflow),
        .o_busy         (busy),
        .o_seg_party    (segParty),
        .o_seg_count    (segCount)
`ifdef EVM_WINNER_EN
        ,
        .o_winner       (winner),
        .o_winner_valid (winnerValid),
        .o_tie          (tie)
`endif
    );

    evm_multi_party #(.N_PARTY(16), .CNT_W(8)) dutWide (
        .i_clk          (clk),
        .i_reset_n      (resetN),
        .i_voting_en    (votingEn),
        .i_officer_arm  (officerArm),
        .i_voter_switch ({12'b0, voterSwitch}),
        .i_push_button  (pushButton),
        .i_sel_party    (selWide),
        .i_show_count   (showCount),
        .o_party_count  (wPartyCount),
        .o_total_count  (wTotalCount),
        .o_vote_ack     (wVoteAck),
        .o_invalid_vote (wInvalidVote),
        .o_overflow     (wOverflow),
        .o_busy         (wBusy),
        .o_seg_party    (wSegParty),
        .o_seg_count    (wSegCount)
`ifdef EVM_WINNER_EN
        ,
        .o_winner       (wWinner),
        .o_winner_valid (wWinnerValid),
        .o_tie          (wTie)
`endif
    );

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] sw, input logic btn);
        voterSwitch = sw;
        pushButton  = btn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push. The expected ack comes from the counter model, which
    // saturates at 3 for the 2-bit instance.
    task automatic pushVote(input int party, input string tag);
        voteExpect_t e;
        e.tag = tag;
        if (modelCnt[party] == 3) begin
            e.ack    = 1'b0;
            modelOvf = 1'b1;
        end else begin
            e.ack = 1'b1;
            modelCnt[party]++;
        end
        sbQ.push_back(e);
    endtask

    // Scoreboard pop in the COMMIT cycle.
    task automatic checkVote();
        voteExpect_t e;
        checkOutput("sb_pending", 32'(sbQ.size() > 0), 1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e.tag, voteAck, e.ack);
        end
    endtask

    task automatic checkCounts(input string tag);
        for (int p = 0; p < 4; p++) begin
            selParty = 2'(p);
            #1;
            checkOutput($sformatf("%s_cnt%0d", tag, p), partyCount, modelCnt[p]);
        end
    endtask

    // Full vote from READY: arm, cast, release, then back to READY.
    task automatic doVote(input int party);
        officerArm = 1'b1;
        tick();
        officerArm = 1'b0;
        pushVote(party, $sformatf("ack_party%0d", party));
        applyStimulus(4'(1 << party), 1'b1);
        tick();
        checkVote();
        applyStimulus(4'(1 << party), 1'b0);
        tick();
        tick();
    endtask

    initial begin
        resetN     = 1'b0;
        votingEn   = 1'b0;
        officerArm = 1'b0;
        selParty   = '0;
        selWide    = '0;
        showCount  = 1'b1;
        modelOvf   = 1'b0;
        for (int p = 0; p < 4; p++) modelCnt[p] = 0;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_party_count", partyCount, 0);
        checkOutput("rst_total", totalCount, 0);
        checkOutput("rst_ack", voteAck, 0);
        checkOutput("rst_invalid", invalidVote, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_seg_count", segCount, 7'b1111111);

        resetN = 1'b1;
        tick();
        checkOutput("seg_count_zero", segCount, 7'b0000001);
        showCount = 1'b0;
        #1;
        checkOutput("seg_count_blank", segCount, 7'b1111111);
        showCount = 1'b1;

        $display("[TB] party digit decode");
        for (int s = 0; s < 4; s++) begin
            selParty = 2'(s);
            #1;
            checkOutput($sformatf("seg_party_%0d", s), segParty, segRef[s + 1]);
        end
        for (int s = 0; s < 16; s++) begin
            selWide = 4'(s);
            #1;
            checkOutput($sformatf("wide_seg_party_%0d", s), wSegParty,
                        (s == 15) ? 7'b1111110 : segRef[s + 1]);
        end
        selWide = '0;
        tick();

        $display("[TB] single vote");
        votingEn = 1'b1;
        tick();
        checkOutput("ready_not_busy", busy, 0);
        officerArm = 1'b1;
        tick();
        checkOutput("armed_busy", busy, 1);
        pushVote(1, "ack_first_vote");
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkVote();
        tick();
        selParty = 2'd1;
        #1;
        checkOutput("count1_one", partyCount, 1);
        checkOutput("ack_single_pulse", voteAck, 0);
        checkOutput("total_lag", totalCount, 0);
        checkOutput("seg_count_one", segCount, 7'b1001111);
        tick();
        checkOutput("total_one", totalCount, 1);

        $display("[TB] held button and arm");
        ackCount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ackCount += int'(voteAck);
        end
        checkOutput("held_no_ack", ackCount, 0);
        checkOutput("held_busy", busy, 1);
        checkOutput("held_count1", partyCount, 1);
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("lockout_arm_held", busy, 1);
        officerArm = 1'b0;
        tick();
        checkOutput("lockout_release", busy, 0);

        $display("[TB] invalid switch");
        officerArm = 1'b1;
        tick();
        officerArm = 1'b0;
        applyStimulus(4'b0110, 1'b1);
        tick();
        checkOutput("invalid_pulse", invalidVote, 1);
        checkOutput("invalid_still_armed", busy, 1);
        applyStimulus(4'b0110, 1'b0);
        tick();
        checkOutput("invalid_one_cycle", invalidVote, 0);
        checkCounts("after_invalid");
        checkOutput("invalid_total", totalCount, 1);
        pushVote(2, "ack_party2_after_invalid");
        applyStimulus(4'b0100, 1'b1);
        tick();
        checkVote();
        applyStimulus(4'b0100, 1'b0);
        tick();
        tick();
        checkCounts("after_party2");
        checkOutput("total_two", totalCount, 2);
        checkOutput("back_to_ready", busy, 0);

        $display("[TB] saturation");
        for (int v = 0; v < 3; v++) doVote(0);
        checkOutput("no_overflow_yet", overflow, 0);
        doVote(0);
        checkOutput("overflow_sticky", overflow, modelOvf);
        checkCounts("after_sat");
        checkOutput("total_sat", totalCount, 5);

        $display("[TB] session drop and reset in commit");
        officerArm = 1'b1;
        tick();
        officerArm = 1'b0;
        checkOutput("armed_before_drop", busy, 1);
        votingEn = 1'b0;
        tick();
        checkOutput("drop_idle", busy, 0);
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkOutput("idle_no_ack", voteAck, 0);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkCounts("after_drop");
        checkOutput("drop_total", totalCount, 5);
        checkOutput("drop_overflow", overflow, 1);

        votingEn = 1'b1;
        tick();
        officerArm = 1'b1;
        tick();
        officerArm = 1'b0;
        pushVote(1, "ack_before_reset");
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkVote();
        resetN = 1'b0;
        tick();
        for (int p = 0; p < 4; p++) modelCnt[p] = 0;
        modelOvf = 1'b0;
        checkCounts("after_reset");
        checkOutput("reset_total", totalCount, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_seg_blank", segCount, 7'b1111111);
        resetN = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();

`ifdef EVM_WINNER_EN
        $display("[TB] winner scan");
        for (int v = 0; v < 2; v++) doVote(0);
        for (int v = 0; v < 5; v++) doVote(1);
        for (int v = 0; v < 5; v++) doVote(2);
        doVote(3);
        checkOutput("win_scanning", winnerValid, 0);
        tick();
        tick();
        tick();
        checkOutput("win_valid", winnerValid, 1);
        checkOutput("win_index", winner, 1);
        checkOutput("win_tie", tie, 1);
        for (int i = 0; i < 11; i++) tick();
        checkOutput("wide_win_scanning", wWinnerValid, 0);
        tick();
        checkOutput("wide_win_valid", wWinnerValid, 1);
        checkOutput("wide_win_index", wWinner, 1);
        checkOutput("wide_win_tie", wTie, 1);
        checkOutput("overflow_after_win", overflow, modelOvf);
`endif

        checkOutput("sb_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
